panel_io_sequencer: RTL and testbench
=====================================

Name: panel_io_sequencer

Overview:
Front-panel I/O frame sequencer. It repeatedly parallel-loads the serial DIP/switch input chain and shifts the chain in (16 DIP bits + 5 switch bits). In the same shift clocks it shifts a 16-bit LED word out to the LED shift chain, then latches both sides. It sits between the board's serial panel chains and the CPU datapath, and gives the core a registered DIP/switch snapshot and a buffered LED write port.

Parameters:
DIV, 4, system clocks per shift-clock period; even, >= 2
DIP_BITS, 21, bits shifted in per frame (16 DIP + 5 switch); fixed, documented for the bench
LED_BITS, 16, LED bits shifted out per frame; fixed
GAP_CYCLES, 8, idle clocks between frames; >= 1

Ports:
i_CLK  in  1  system clock, all logic on rising edge
i_RESET  in  1  synchronous reset, active-high
i_Enable  in  1  run frames continuously while high
i_SerIn  in  1  serial data from DIP/switch chain
o_SerLoad  out  1  parallel-load strobe to input chain
o_ShiftCLK  out  1  shift clock shared by both chains
o_LEDData  out  1  serial LED data, MSB first
o_LEDLatch  out  1  LED chain latch strobe
i_LEDWr  in  1  one-cycle write strobe for LED word
i_LEDValue  in  16  LED word, captured when i_LEDWr=1
o_DIP16  out  16  last captured DIP value
o_Switch5  out  5  last captured switch value
o_InValid  out  1  1-cycle pulse: new snapshot on o_DIP16/o_Switch5
o_Changed  out  1  1-cycle pulse with o_InValid when snapshot differs from previous one

Behaviour:
- Reset: state IDLE; all outputs 0; pending LED register and previous-snapshot register set to 0. Reset in any state aborts the frame immediately: no latch, no o_InValid, o_DIP16/o_Switch5 cleared.
- Pending LED register: loaded with i_LEDValue on any cycle with i_LEDWr=1, in any state; last write wins. Shadow register is set to pending on the clock LOAD is entered. A write on that same clock reaches only the next frame.
- FSM states: IDLE, LOAD, SHIFT, LATCH, GAP.
- IDLE: all strobes 0. Enters LOAD on the clock after i_Enable is sampled 1.
- LOAD: DIV cycles, o_SerLoad=1, o_ShiftCLK=0. Then SHIFT.
- SHIFT: 21 bit periods of DIV cycles each, numbered k=0..20.
  - o_ShiftCLK is 0 for the first DIV/2 cycles and 1 for the last DIV/2 cycles of each period.
  - i_SerIn is sampled on the last low-half cycle of each period.
  - The first sampled bit goes to cap[20] (MSB first).
  - o_LEDData changes only at a period start: 0 for k=0..4, shadow[20-k] for k=5..20. After 21 clocks the LED chain therefore holds shadow[15:0].
  - After the last period: go to LATCH.
- LATCH: DIV cycles, o_LEDLatch=1, o_LEDData=0.
  - On the first LATCH cycle: o_DIP16<=cap[20:5], o_Switch5<=cap[4:0], o_InValid=1, o_Changed=(cap != previous snapshot); previous snapshot <= cap.
  - Then GAP.
- GAP: GAP_CYCLES cycles, all strobes 0. Then LOAD if i_Enable=1, else IDLE.
- i_Enable low mid-frame: the current frame completes normally; the enable check happens only at the end of GAP.
- Frame period with defaults = DIV + 21*DIV + DIV + GAP_CYCLES = 100 clocks. Outputs update at offset 88 from the first LOAD cycle (offset 0).
- o_InValid and o_Changed never assert outside the first LATCH cycle. The first frame after reset compares against 0.
- Counters: bit counter 5 bits, cycle counter ceil(log2(max(DIV, GAP_CYCLES))) bits. No wrap: each counter is reloaded on every state entry.

Test Plan:
1. Reset 2 cycles, i_Enable=1, i_SerIn stream 1,0,0,0,0,1,1,0,0,1,0,0,1,0,0,0,1,0,1,1,1 (one bit per period) -> at offset 88: o_DIP16=16'h8648, o_Switch5=5'h17, o_InValid=1 and o_Changed=1 for exactly 1 cycle; o_SerLoad high offsets 0-3.
2. i_LEDWr with 16'hA5C3 before enable -> o_LEDData sampled at o_ShiftCLK rising edges = 0,0,0,0,0 then 1010010111000011; o_LEDLatch high offsets 88-91; next LOAD at offset 100.
3. LED write 16'h00FF at offset 40 during a frame carrying 16'hA5C3 -> that frame shifts A5C3; next frame shifts 00FF.
4. Two consecutive frames with identical i_SerIn streams -> second frame o_InValid=1, o_Changed=0, outputs unchanged.
5. i_RESET=1 at offset 50 for 1 cycle, i_Enable held 1 -> all outputs 0 the next cycle, no o_LEDLatch/o_InValid; LOAD restarts the clock after reset is released.
6. i_Enable dropped at offset 30 -> frame finishes (latch at 88), GAP, then IDLE; o_ShiftCLK/o_SerLoad stay 0 afterwards; re-asserting enable starts LOAD the next clock.

Source files
------------

// File: rtl/panel_io_sequencer_if.sv
// Panel sequencer bundle: enable, serial chains, LED write port, snapshot.
// master drives the inputs (core/board side); slave is the sequencer.
interface panel_io_sequencer_if;
    logic        i_Enable;
    logic        i_SerIn;
    logic        o_SerLoad;
    logic        o_ShiftCLK;
    logic        o_LEDData;
    logic        o_LEDLatch;
    logic        i_LEDWr;
    logic [15:0] i_LEDValue;
    logic [15:0] o_DIP16;
    logic [4:0]  o_Switch5;
    logic        o_InValid;
    logic        o_Changed;

    modport master (
        output i_Enable, i_SerIn, i_LEDWr, i_LEDValue,
        input  o_SerLoad, o_ShiftCLK, o_LEDData, o_LEDLatch,
        input  o_DIP16, o_Switch5, o_InValid, o_Changed
    );

    modport slave (
        input  i_Enable, i_SerIn, i_LEDWr, i_LEDValue,
        output o_SerLoad, o_ShiftCLK, o_LEDData, o_LEDLatch,
        output o_DIP16, o_Switch5, o_InValid, o_Changed
    );
endinterface

// File: rtl/panel_io_sequencer.sv
// Front-panel frame sequencer: loads/shifts 21 DIP+switch bits in,
// 16 LED bits out, latches both. Ports: i_CLK, i_RESET, io (slave).
module panel_io_sequencer #(
    parameter int DIV        = 4,
    parameter int DIP_BITS   = 21,
    parameter int LED_BITS   = 16,
    parameter int GAP_CYCLES = 8
) (
    input logic                 i_CLK,
    input logic                 i_RESET,
    panel_io_sequencer_if.slave io
);
    localparam int CMAX = (DIV > GAP_CYCLES) ? DIV : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX);
    localparam int LEAD = DIP_BITS - LED_BITS;

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT, LATCH, GAP
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_reload;
    logic [4:0]            bit_q;
    logic [3:0]            led_idx;
    logic [LED_BITS-1:0]   pending_q, shadow_q;
    logic [DIP_BITS-1:0]   cap_q, prev_q;
    logic [LED_BITS-1:0]   dip_q;
    logic [LEAD-1:0]       sw_q;
    logic                  valid_q, changed_q;
    logic                  ser_load, shift_clk;
    logic                  led_data, led_latch;
    logic                  entering;
    logic                  last_bit;

    always_ff @(posedge i_CLK) begin
        if (i_RESET) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ser_load  = 1'b0;
        shift_clk = 1'b0;
        led_data  = 1'b0;
        led_latch = 1'b0;
        last_bit  = (bit_q == 5'(DIP_BITS - 1));
        // LED chain is shorter: pad the first LEAD periods with zeros
        led_idx   = 4'(5'(DIP_BITS - 1) - bit_q);
        unique case (state_q)
            IDLE: begin
                if (io.i_Enable) state_d = LOAD;
            end
            LOAD: begin
                ser_load = 1'b1;
                if (cnt_q == '0) state_d = SHIFT;
            end
            SHIFT: begin
                shift_clk = (cnt_q < CW'(DIV / 2));
                if (bit_q >= 5'(LEAD))
                    led_data = shadow_q[led_idx];
                if (cnt_q == '0 && last_bit) state_d = LATCH;
            end
            LATCH: begin
                led_latch = 1'b1;
                if (cnt_q == '0) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == '0)
                    state_d = io.i_Enable ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
        entering   = (state_d != state_q);
        cnt_reload = (state_d == GAP) ? CW'(GAP_CYCLES - 1)
                                      : CW'(DIV - 1);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt_q     <= '0;
            bit_q     <= '0;
            pending_q <= '0;
            shadow_q  <= '0;
            cap_q     <= '0;
            prev_q    <= '0;
            dip_q     <= '0;
            sw_q      <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            if (io.i_LEDWr) pending_q <= io.i_LEDValue;
            // shadow takes the value pending before this edge's write
            if (entering && state_d == LOAD) shadow_q <= pending_q;
            if (entering) begin
                cnt_q <= cnt_reload;
                bit_q <= '0;
            end else if (state_q == SHIFT && cnt_q == '0) begin
                cnt_q <= CW'(DIV - 1);
                bit_q <= bit_q + 5'd1;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            // last low-half cycle: data is stable before the rising edge
            if (state_q == SHIFT && cnt_q == CW'(DIV / 2))
                cap_q <= {cap_q[DIP_BITS-2:0], io.i_SerIn};
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            if (entering && state_d == LATCH) begin
                dip_q     <= cap_q[DIP_BITS-1:LEAD];
                sw_q      <= cap_q[LEAD-1:0];
                valid_q   <= 1'b1;
                changed_q <= (cap_q != prev_q);
                prev_q    <= cap_q;
            end
        end
    end

    assign io.o_SerLoad  = ser_load;
    assign io.o_ShiftCLK = shift_clk;
    assign io.o_LEDData  = led_data;
    assign io.o_LEDLatch = led_latch;
    assign io.o_DIP16    = dip_q;
    assign io.o_Switch5  = sw_q;
    assign io.o_InValid  = valid_q;
    assign io.o_Changed  = changed_q;
endmodule

// File: tb/tb_panel_io_sequencer.sv
// Bench for panel_io_sequencer: frame timing, LED shift-out,
// snapshot scoreboard, mid-frame reset and enable drop.
module tb_panel_io_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    panel_io_sequencer_if io();

    panel_io_sequencer dut (
        .i_CLK  (clk),
        .i_RESET(rst),
        .io     (io)
    );

    typedef struct packed {
        logic [15:0] dip;
        logic [4:0]  sw;
        logic        chg;
    } snap_t;

    snap_t       sb_snap[$];
    logic [20:0] sb_led[$];
    logic [20:0] prev_word;
    logic [20:0] shown;
    logic [15:0] pend_m;
    int          errors = 0;
    int          checks = 0;

    task automatic run_frame(input logic [20:0] word,
                             input int wr_at,
                             input logic [15:0] wr_val,
                             input int abort_at,
                             input int drop_at);
        int          n;
        int          k;
        logic [15:0] led_f;
        logic [20:0] led_cap;
        int          rises;
        logic        sclk_p;
        logic        latch_p;
        logic        chg;
        logic [5:0]  exp_s;
        logic [5:0]  act_s;
        logic [20:0] exp_h;
        snap_t       s;
        logic [20:0] l;
        n = 0;
        while (io.o_SerLoad !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL load_timeout act=no LOAD req=LOAD");
            return;
        end
        chg = (word != prev_word);
        sb_snap.push_back({word[20:5], word[4:0], chg});
        sb_led.push_back({5'b0, pend_m});
        led_f     = pend_m;
        prev_word = word;
        led_cap   = '0;
        rises     = 0;
        sclk_p    = 1'b0;
        latch_p   = 1'b0;
        for (int t = 0; t < 100; t++) begin
            k = (t - 4) / 4;
            exp_s = '0;
            exp_s[5] = (t < 4);
            if (t >= 4 && t < 88) begin
                exp_s[4] = (((t - 4) % 4) >= 2);
                exp_s[3] = (k >= 5) ? led_f[20-k] : 1'b0;
            end
            exp_s[2] = (t >= 88 && t < 92);
            exp_s[1] = (t == 88);
            exp_s[0] = (t == 88) ? chg : 1'b0;
            act_s = {io.o_SerLoad, io.o_ShiftCLK, io.o_LEDData,
                     io.o_LEDLatch, io.o_InValid, io.o_Changed};
            checks++;
            if (act_s !== exp_s) begin
                errors++;
                $display("FAIL strobes t=%0d act=%b req=%b",
                         t, act_s, exp_s);
            end
            exp_h = (t >= 88) ? word : shown;
            checks++;
            if ({io.o_DIP16, io.o_Switch5} !== exp_h) begin
                errors++;
                $display("FAIL snapshot_hold t=%0d act=%h req=%h",
                         t, {io.o_DIP16, io.o_Switch5}, exp_h);
            end
            if (io.o_ShiftCLK === 1'b1 && !sclk_p) begin
                led_cap = {led_cap[19:0], io.o_LEDData};
                rises++;
            end
            sclk_p = io.o_ShiftCLK;
            if (io.o_InValid === 1'b1 && sb_snap.size() > 0) begin
                s = sb_snap.pop_front();
                checks++;
                if ({io.o_DIP16, io.o_Switch5, io.o_Changed} !== s) begin
                    errors++;
                    $display("FAIL snap t=%0d act=%h/%h/%b req=%h/%h/%b",
                             t, io.o_DIP16, io.o_Switch5, io.o_Changed,
                             s.dip, s.sw, s.chg);
                end
            end
            if (io.o_LEDLatch === 1'b1 && !latch_p
                && sb_led.size() > 0) begin
                l = sb_led.pop_front();
                checks++;
                if (led_cap !== l || rises != 21) begin
                    errors++;
                    $display("FAIL led_word act=%h/%0d req=%h/21",
                             led_cap, rises, l);
                end
            end
            latch_p = io.o_LEDLatch;
            if (t >= 4 && t < 88 && ((t - 4) % 4) == 0)
                io.i_SerIn = word[20-k];
            io.i_LEDWr = (t == wr_at);
            if (t == wr_at) begin
                io.i_LEDValue = wr_val;
                pend_m        = wr_val;
            end
            if (t == drop_at) io.i_Enable = 1'b0;
            if (t == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                act_s = {io.o_SerLoad, io.o_ShiftCLK, io.o_LEDData,
                         io.o_LEDLatch, io.o_InValid, io.o_Changed};
                checks++;
                if ({act_s, io.o_DIP16, io.o_Switch5} !== '0) begin
                    errors++;
                    $display("FAIL abort_zero act=%b/%h/%h req=0",
                             act_s, io.o_DIP16, io.o_Switch5);
                end
                sb_snap.delete();
                sb_led.delete();
                prev_word = '0;
                shown     = '0;
                pend_m    = '0;
                return;
            end
            @(negedge clk);
        end
        shown = word;
        checks++;
        if (sb_snap.size() != 0 || sb_led.size() != 0) begin
            errors++;
            $display("FAIL frame_drain act=%0d/%0d left req=0/0",
                     sb_snap.size(), sb_led.size());
            sb_snap.delete();
            sb_led.delete();
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        io.i_Enable   = 1'b0;
        io.i_SerIn    = 1'b0;
        io.i_LEDWr    = 1'b0;
        io.i_LEDValue = '0;
        prev_word     = '0;
        shown         = '0;
        pend_m        = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({io.o_SerLoad, io.o_ShiftCLK, io.o_LEDData, io.o_LEDLatch,
             io.o_InValid, io.o_Changed, io.o_DIP16, io.o_Switch5}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs act=nonzero req=0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_frame;
        io.i_LEDWr    = 1'b1;
        io.i_LEDValue = 16'hA5C3;
        pend_m        = 16'hA5C3;
        @(negedge clk);
        io.i_LEDWr  = 1'b0;
        io.i_Enable = 1'b1;
        run_frame(21'b100001100100100010111, -1, '0, -1, -1);
    endtask

    task automatic test_led_rewrite;
        run_frame(21'h0ABCDE, 40, 16'h00FF, -1, -1);
        run_frame(21'h13579B, -1, '0, -1, -1);
    endtask

    task automatic test_back_to_back;
        run_frame(21'h1F00F1, -1, '0, -1, -1);
        run_frame(21'h1F00F1, -1, '0, -1, -1);
        run_frame(21'($urandom), 20, 16'h3C5A, -1, -1);
    endtask

    task automatic test_reset_midframe;
        run_frame(21'h0F0F0F, -1, '0, 50, -1);
        @(negedge clk);
        checks++;
        if (io.o_SerLoad !== 1'b1) begin
            errors++;
            $display("FAIL restart_load act=%b req=1", io.o_SerLoad);
        end
        run_frame(21'h0F0F0F, -1, '0, -1, -1);
    endtask

    task automatic test_enable_drop;
        run_frame(21'h155555, -1, '0, -1, 30);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({io.o_SerLoad, io.o_ShiftCLK, io.o_LEDLatch}
                !== 3'b000) begin
                errors++;
                $display("FAIL idle_quiet i=%0d act=%b req=000", i,
                         {io.o_SerLoad, io.o_ShiftCLK, io.o_LEDLatch});
            end
            @(negedge clk);
        end
        io.i_Enable = 1'b1;
        @(negedge clk);
        checks++;
        if (io.o_SerLoad !== 1'b1) begin
            errors++;
            $display("FAIL reenable_load act=%b req=1", io.o_SerLoad);
        end
        run_frame(21'h0AAAAA, -1, '0, -1, 60);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_led_rewrite();
        test_back_to_back();
        test_reset_midframe();
        test_enable_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
